// File: rtl/issue_queue_scoreboard.sv
// issue_queue_scoreboard: in-order issue queue with pending-register scoreboard, completion bypass and flush
module issue_queue_scoreboard #(
  parameter int p_depth        = 4,
  parameter int p_num_pipes    = 2,
  parameter int p_num_classes  = 4,
  parameter int p_seq_num_bits = 8,
  parameter logic [p_num_pipes*p_num_classes-1:0] p_pipe_masks = '1,
  localparam int CW   = p_num_classes > 1 ? $clog2(p_num_classes) : 1,
  localparam int CNTW = $clog2(p_depth + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_val,
  output logic                      enq_rdy,
  input  logic [31:0]               enq_inst,
  input  logic [31:0]               enq_pc,
  input  logic [p_seq_num_bits-1:0] enq_seq_num,
  input  logic [CW-1:0]             enq_class,
  input  logic                      enq_ren0,
  input  logic                      enq_ren1,
  input  logic [4:0]                enq_raddr0,
  input  logic [4:0]                enq_raddr1,
  input  logic                      enq_wen,
  input  logic [4:0]                enq_waddr,
  output logic [p_num_pipes-1:0]    iss_val,
  input  logic [p_num_pipes-1:0]    iss_rdy,
  output logic [31:0]               iss_inst,
  output logic [31:0]               iss_pc,
  output logic [p_seq_num_bits-1:0] iss_seq_num,
  output logic [4:0]                iss_raddr0,
  output logic [4:0]                iss_raddr1,
  output logic                      iss_wen,
  output logic [4:0]                iss_waddr,
  input  logic                      cmp_val,
  input  logic                      cmp_wen,
  input  logic [4:0]                cmp_waddr,
  input  logic                      flush,
  output logic [CNTW-1:0]           count
);
  localparam int PW = p_depth > 1 ? $clog2(p_depth) : 1;
  typedef struct packed {
    logic [31:0]               inst;
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq;
    logic [CW-1:0]             cls;
    logic                      ren0;
    logic                      ren1;
    logic                      wen;
    logic [4:0]                ra0;
    logic [4:0]                ra1;
    logic [4:0]                wa;
  } entry_t;
  entry_t          mem_q [p_depth];
  entry_t          mem_d [p_depth];
  entry_t          head;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [31:0]     pend_q, pend_d, cmp_clr, live;
  logic            blocked, can_iss, iss_xfer, enq_xfer;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(p_depth - 1) ? '0 : p + 1'b1;
  endfunction
  function automatic logic haz(input logic en, input logic [4:0] a, input logic [31:0] pend);
    return en && a != 5'd0 && pend[a];
  endfunction
  assign head        = mem_q[head_q];
  assign cmp_clr     = (cmp_val && cmp_wen) ? (32'd1 << cmp_waddr) : 32'd0;
  assign live        = pend_q & ~cmp_clr;
  assign blocked     = haz(head.ren0, head.ra0, live) || haz(head.ren1, head.ra1, live) || haz(head.wen, head.wa, live);
  assign can_iss     = count_q != '0 && !flush && !blocked;
  assign enq_rdy     = count_q < CNTW'(p_depth) && !flush && !rst;
  assign enq_xfer    = enq_val && enq_rdy;
  assign iss_xfer    = |(iss_val & iss_rdy);
  assign iss_inst    = head.inst;
  assign iss_pc      = head.pc;
  assign iss_seq_num = head.seq;
  assign iss_raddr0  = head.ra0;
  assign iss_raddr1  = head.ra1;
  assign iss_wen     = head.wen;
  assign iss_waddr   = head.wa;
  assign count       = count_q;
  // route the head to the lowest-index ready pipe that accepts its class
  always_comb begin
    iss_val = '0;
    for (int i = p_num_pipes - 1; i >= 0; i--)
      if (int'(head.cls) < p_num_classes && p_pipe_masks[i*p_num_classes + int'(head.cls)] && iss_rdy[i]) begin
        iss_val    = '0;
        iss_val[i] = can_iss;
      end
  end
  // next queue/scoreboard state; an issue setting a register beats a same-cycle completion clearing it
  always_comb begin
    mem_d   = mem_q;
    head_d  = iss_xfer ? nxt(head_q) : head_q;
    tail_d  = enq_xfer ? nxt(tail_q) : tail_q;
    count_d = count_q + CNTW'(enq_xfer) - CNTW'(iss_xfer);
    pend_d  = live;
    if (iss_xfer && head.wen) pend_d[head.wa] = 1'b1;
    pend_d[0] = 1'b0;
    if (enq_xfer) mem_d[tail_q] = '{inst: enq_inst, pc: enq_pc, seq: enq_seq_num, cls: enq_class,
                                    ren0: enq_ren0, ren1: enq_ren1, wen: enq_wen,
                                    ra0: enq_raddr0, ra1: enq_raddr1, wa: enq_waddr};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end
  // state registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_issue_queue_scoreboard.sv
// tb_issue_queue_scoreboard: directed and random stimulus against a queue-based reference model
module tb_issue_queue_scoreboard;
  localparam int DEPTH = 3;
  localparam int PIPES = 2;
  localparam logic [7:0] MASKS = 8'b0011_0001;
  typedef struct {
    logic [31:0] inst, pc;
    logic [7:0]  seq;
    logic [1:0]  cls;
    logic        ren0, ren1, wen;
    logic [4:0]  ra0, ra1, wa;
  } ent_t;
  logic clk = 1'b0, rst;
  logic enq_val, enq_rdy, enq_ren0, enq_ren1, enq_wen;
  logic [31:0] enq_inst, enq_pc, iss_inst, iss_pc;
  logic [7:0] enq_seq_num, iss_seq_num;
  logic [1:0] enq_class, iss_val, iss_rdy, count;
  logic [4:0] enq_raddr0, enq_raddr1, enq_waddr, iss_raddr0, iss_raddr1, iss_waddr, cmp_waddr;
  logic iss_wen, cmp_val, cmp_wen, flush;
  int checks = 0, errors = 0, maxc = 0;
  ent_t q[$];
  logic [7:0] log_q[$];
  logic [31:0] pend_m = '0;
  logic [7:0] sn = '0;
  issue_queue_scoreboard #(.p_depth(DEPTH), .p_num_pipes(PIPES), .p_num_classes(4),
                           .p_seq_num_bits(8), .p_pipe_masks(MASKS)) dut (
    .clk(clk), .rst(rst), .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_seq_num(enq_seq_num), .enq_class(enq_class), .enq_ren0(enq_ren0), .enq_ren1(enq_ren1),
    .enq_raddr0(enq_raddr0), .enq_raddr1(enq_raddr1), .enq_wen(enq_wen), .enq_waddr(enq_waddr),
    .iss_val(iss_val), .iss_rdy(iss_rdy), .iss_inst(iss_inst), .iss_pc(iss_pc), .iss_seq_num(iss_seq_num),
    .iss_raddr0(iss_raddr0), .iss_raddr1(iss_raddr1), .iss_wen(iss_wen), .iss_waddr(iss_waddr),
    .cmp_val(cmp_val), .cmp_wen(cmp_wen), .cmp_waddr(cmp_waddr), .flush(flush), .count(count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit blk(input logic en, input logic [4:0] a);
    return en && a != 0 && pend_m[a] && !(cmp_val && cmp_wen && cmp_waddr == a);
  endfunction
  task automatic idle();
    enq_val = 0; enq_ren0 = 0; enq_ren1 = 0; enq_wen = 0; enq_class = 0;
    enq_raddr0 = 0; enq_raddr1 = 0; enq_waddr = 0; enq_seq_num = 0;
    iss_rdy = 0; cmp_val = 0; cmp_wen = 0; cmp_waddr = 0; flush = 0;
  endtask
  task automatic enq(input logic [1:0] c, input logic r0, input logic [4:0] a0,
                     input logic r1, input logic [4:0] a1, input logic w, input logic [4:0] wa);
    enq_val = 1; enq_class = c; enq_ren0 = r0; enq_raddr0 = a0; enq_ren1 = r1; enq_raddr1 = a1;
    enq_wen = w; enq_waddr = wa; enq_seq_num = sn; sn++;
    enq_inst = $urandom; enq_pc = $urandom;
  endtask
  task automatic cmp(input logic [4:0] a);
    cmp_val = 1; cmp_wen = 1; cmp_waddr = a;
  endtask
  // one clock: check outputs against the model mid-cycle, then advance the model at the edge
  task automatic cyc();
    ent_t h;
    int sel;
    logic [1:0] ev;
    bit er, ix, ex;
    #1;
    if (rst) begin q.delete(); pend_m = '0; end
    er = !rst && !flush && q.size() < DEPTH;
    ev = '0; sel = -1;
    if (q.size() > 0) h = q[0];
    if (q.size() > 0 && !flush && !rst && !(blk(h.ren0, h.ra0) || blk(h.ren1, h.ra1) || blk(h.wen, h.wa)))
      for (int i = 0; i < PIPES; i++)
        if (MASKS[i*4 + int'(h.cls)] && iss_rdy[i]) begin sel = i; break; end
    if (sel >= 0) ev[sel] = 1'b1;
    chk("count", count, q.size());
    chk("enq_rdy", enq_rdy, er);
    chk("iss_val", iss_val, ev);
    if (q.size() > 0)
      chk("head_data", {iss_inst, iss_pc, iss_seq_num, iss_raddr0, iss_raddr1, iss_wen, iss_waddr},
                       {h.inst, h.pc, h.seq, h.ra0, h.ra1, h.wen, h.wa});
    if (|(iss_val & iss_rdy)) log_q.push_back(iss_seq_num);
    if (int'(count) > maxc) maxc = count;
    ix = ev != 0;
    ex = enq_val && er;
    @(posedge clk);
    if (!rst) begin
      if (cmp_val && cmp_wen) pend_m[cmp_waddr] = 1'b0;
      if (flush) q.delete();
      else begin
        if (ix) begin
          if (h.wen && h.wa != 0) pend_m[h.wa] = 1'b1;
          void'(q.pop_front());
        end
        if (ex) q.push_back('{inst: enq_inst, pc: enq_pc, seq: enq_seq_num, cls: enq_class,
                             ren0: enq_ren0, ren1: enq_ren1, wen: enq_wen,
                             ra0: enq_raddr0, ra1: enq_raddr1, wa: enq_waddr});
      end
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1; idle(); enq_inst = 0; enq_pc = 0;
    @(negedge clk);
    cyc();
    chk("rst_count", count, 0);
    rst = 0;
    // fill to depth with nothing ready, then hold one more request
    for (int i = 0; i < DEPTH; i++) begin idle(); enq(0, 0, 0, 0, 0, 0, 0); cyc(); end
    idle(); enq(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("fill_hold", count, DEPTH);
    chk("fill_rdy", enq_rdy, 0);
    idle(); iss_rdy = 2'b11;
    for (int i = 0; i < DEPTH; i++) cyc();
    // RAW: writer of x5 issues, reader stalls until the completion bypass
    idle(); enq(0, 0, 0, 0, 0, 1, 5); cyc();
    idle(); enq(0, 1, 5, 0, 0, 0, 0); iss_rdy = 2'b11; cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("raw_stall", iss_val, 2'b00);
    cmp(5); #1;
    chk("raw_bypass", iss_val, 2'b01);
    cyc();
    // WAW and set-wins on x7
    idle(); enq(0, 0, 0, 0, 0, 1, 7); cyc();
    idle(); enq(0, 0, 0, 0, 0, 1, 7); iss_rdy = 2'b11; cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("waw_stall", iss_val, 2'b00);
    cyc();
    cmp(7); enq(0, 1, 7, 0, 0, 0, 0); #1;
    chk("waw_bypass", iss_val, 2'b01);
    cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("set_wins", iss_val, 2'b00);
    cyc();
    cmp(7); cyc();
    idle(); cyc();
    // pipe routing by class
    idle(); enq(1, 0, 0, 0, 0, 0, 0); cyc();
    enq(0, 0, 0, 0, 0, 0, 0); cyc();
    enq(2, 0, 0, 0, 0, 0, 0); cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("route_c1", iss_val, 2'b10);
    cyc();
    iss_rdy = 2'b01; #1;
    chk("route_c0", iss_val, 2'b01);
    cyc();
    iss_rdy = 2'b11; #1;
    chk("route_none", iss_val, 2'b00);
    cyc();
    idle(); flush = 1; cyc();
    // back-to-back enqueue/issue across pointer wrap
    sn = 0; log_q.delete(); maxc = 0;
    for (int i = 0; i < 10; i++) begin idle(); enq(0, 0, 0, 0, 0, 0, 0); iss_rdy = 2'b11; cyc(); end
    idle(); iss_rdy = 2'b11; cyc(); cyc();
    chk("wrap_n", log_q.size(), 10);
    for (int i = 0; i < log_q.size() && i < 10; i++) chk("wrap_order", log_q[i], i);
    chk("wrap_max", maxc <= DEPTH, 1);
    // flush keeps pending bits
    idle(); enq(0, 0, 0, 0, 0, 1, 9); cyc();
    idle(); iss_rdy = 2'b11; cyc();
    for (int i = 0; i < DEPTH; i++) begin idle(); enq(0, 0, 0, 0, 0, 0, 0); cyc(); end
    idle();
    chk("pre_flush", count, DEPTH);
    flush = 1; cyc();
    flush = 0;
    chk("flush_count", count, 0);
    chk("flush_val", iss_val, 2'b00);
    enq(0, 0, 0, 1, 9, 0, 0); iss_rdy = 2'b11; cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("flush_pend", iss_val, 2'b00);
    cyc();
    cmp(9); cyc();
    // x0 is never pending
    idle(); enq(0, 0, 0, 0, 0, 1, 0); cyc();
    idle(); enq(0, 1, 0, 0, 0, 0, 0); iss_rdy = 2'b11; cyc();
    idle(); iss_rdy = 2'b11; #1;
    chk("x0_never", iss_val, 2'b01);
    cyc();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        enq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)));
      iss_rdy = 2'($urandom_range(0, 3));
      cmp_val = 1'($urandom_range(0, 1));
      cmp_wen = $urandom_range(0, 3) != 0;
      cmp_waddr = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 15) == 0;
      cyc();
    end
    // asynchronous reset in the middle of traffic
    idle(); enq(0, 0, 0, 0, 0, 1, 3); cyc();
    enq(0, 0, 0, 0, 0, 0, 0); cyc();
    idle(); iss_rdy = 2'b11; rst = 1; #1;
    chk("arst_count", count, 0);
    chk("arst_val", iss_val, 2'b00);
    cyc();
    rst = 0; idle(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
